// File: rtl/johnson_pkg.sv
// +--------------------------------------------------------------------+
// | johnson_pkg: shared types, code constants and successor helper      |
// | for the 3-bit Johnson phase monitor.            Revision: 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

package johnson_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Codes are {Q2,Q1,Q0}; phase n is the n-th code of the count sequence
  localparam logic [2:0] c_code_p0 = 3'b001;
  localparam logic [2:0] c_code_p1 = 3'b011;
  localparam logic [2:0] c_code_p2 = 3'b111;
  localparam logic [2:0] c_code_p3 = 3'b110;
  localparam logic [2:0] c_code_p4 = 3'b100;
  localparam logic [2:0] c_code_p5 = 3'b000;

  localparam logic [2:0] c_code_bad_a = 3'b010;
  localparam logic [2:0] c_code_bad_b = 3'b101;

  function automatic logic [2:0] succ_phase(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_decode.sv
// +--------------------------------------------------------------------+
// | johnson_decode: combinational Johnson code -> phase index, one-hot  |
// | and legality.                                   Revision: 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module johnson_decode
  import johnson_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] phase_idx,
  output logic [5:0] phase_onehot,
  output logic       legal
);

  always_comb begin
    phase_idx = 3'd0;
    legal     = 1'b1;
    case (code)
      c_code_p0: phase_idx = 3'd0;
      c_code_p1: phase_idx = 3'd1;
      c_code_p2: phase_idx = 3'd2;
      c_code_p3: phase_idx = 3'd3;
      c_code_p4: phase_idx = 3'd4;
      c_code_p5: phase_idx = 3'd5;
      default:   legal     = 1'b0;
    endcase
  end

  assign phase_onehot = legal ? (6'b000001 << phase_idx) : 6'b000000;

endmodule

`default_nettype wire

// File: rtl/johnson_phase_monitor.sv
// +--------------------------------------------------------------------+
// | johnson_phase_monitor: decodes an upstream Johnson counter, locks   |
// | onto a clean sequence, flags faults and counts full cycles.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int LOCK_COUNT = 6,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       jc_in,
  input  logic             err_clr,
  output logic [2:0]       phase_idx,
  output logic [5:0]       phase_onehot,
  output logic             phase_valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [CNT_W-1:0] cycle_count,
  output logic             wrap_pulse
);

  localparam logic [3:0]       c_lock    = 4'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [2:0] w_idx;
  logic [5:0] w_onehot;
  logic       w_legal;

  johnson_decode u_decode (
    .code         (jc_in),
    .phase_idx    (w_idx),
    .phase_onehot (w_onehot),
    .legal        (w_legal)
  );

  state_t     r_state;
  logic [3:0] r_run;
  logic       r_prev_valid;
  logic       r_prev_legal;
  logic [2:0] r_prev_idx;

  logic       w_checked;
  logic       w_good;
  logic       w_bad;
  logic [3:0] w_run_inc;

  // A transition is judged only when both ends are legal codes
  assign w_checked = r_prev_valid & r_prev_legal & w_legal;
  assign w_good    = w_checked & (w_idx == succ_phase(r_prev_idx));
  assign w_bad     = w_checked & (w_idx != succ_phase(r_prev_idx));
  assign w_run_inc = r_run + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ACQ;
      r_run        <= 4'd0;
      r_prev_valid <= 1'b0;
      r_prev_legal <= 1'b0;
      r_prev_idx   <= 3'd0;
      phase_idx    <= 3'd0;
      phase_onehot <= 6'd0;
      phase_valid  <= 1'b0;
      locked       <= 1'b0;
      err_illegal  <= 1'b0;
      err_seq      <= 1'b0;
      cycle_count  <= '0;
      wrap_pulse   <= 1'b0;
    end else begin
      r_prev_idx   <= w_idx;
      r_prev_legal <= w_legal;
      r_prev_valid <= 1'b1;
      phase_valid  <= w_legal;
      phase_onehot <= w_onehot;
      if (w_legal) begin
        phase_idx <= w_idx;
      end
      wrap_pulse <= 1'b0;

      case (r_state)
        ACQ: begin
          if (!w_legal || w_bad) begin
            r_run <= 4'd0;
          end else if (w_good) begin
            r_run <= w_run_inc;
            if (w_run_inc == c_lock) begin
              r_state <= TRACK;
              locked  <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (!w_legal || w_bad) begin
            err_illegal <= err_illegal | ~w_legal;
            err_seq     <= err_seq | w_bad;
            r_state     <= FAULT;
            locked      <= 1'b0;
          end else if (w_good && (r_prev_idx == 3'd5)) begin
            cycle_count <= cycle_count + c_cnt_one;
            wrap_pulse  <= 1'b1;
          end
        end
        FAULT: begin
          // The code sampled on the clearing edge is forgotten, so the
          // following code starts a fresh, unchecked history.
          if (err_clr) begin
            err_illegal  <= 1'b0;
            err_seq      <= 1'b0;
            r_run        <= 4'd0;
            r_prev_valid <= 1'b0;
            r_state      <= ACQ;
          end
        end
        default: begin
          r_state <= ACQ;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_johnson_phase_monitor.sv
// +--------------------------------------------------------------------+
// | tb_johnson_phase_monitor: directed and random stimulus compared     |
// | against a behavioural model of the phase monitor. Revision: 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_johnson_phase_monitor;

  localparam int LOCK = 6;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    jc_in;
  logic          err_clr;
  logic [2:0]    phase_idx;
  logic [5:0]    phase_onehot;
  logic          phase_valid;
  logic          locked;
  logic          err_illegal;
  logic          err_seq;
  logic [CW-1:0] cycle_count;
  logic          wrap_pulse;

  always #5 clk = ~clk;

  johnson_phase_monitor #(
    .LOCK_COUNT (LOCK),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .jc_in        (jc_in),
    .err_clr      (err_clr),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .err_illegal  (err_illegal),
    .err_seq      (err_seq),
    .cycle_count  (cycle_count),
    .wrap_pulse   (wrap_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Upstream count sequence, indexed by phase
  logic [2:0] code_of [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

  function automatic int phase_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++)
      if (code_of[i] == c) return i;
    return -1;
  endfunction

  // Behavioural model: mode 0 acquiring, 1 tracking, 2 faulted
  int m_mode, m_run, m_prev, m_idx, m_cnt;
  bit m_hist, m_valid, m_ei, m_es, m_wrap;
  int wraps;

  task automatic model(input logic [2:0] code, input bit clr, input bit rst);
    int  ph;
    bit  judged, good;
    if (rst) begin
      m_mode = 0; m_run = 0; m_prev = -1; m_hist = 0; m_idx = 0;
      m_valid = 0; m_ei = 0; m_es = 0; m_cnt = 0; m_wrap = 0;
      return;
    end
    ph     = phase_of(code);
    judged = m_hist && m_prev >= 0 && ph >= 0;
    good   = judged && ph == (m_prev + 1) % 6;
    m_wrap = 0;
    m_valid = (ph >= 0);
    if (ph >= 0) m_idx = ph;
    if (m_mode == 0) begin
      if (ph < 0 || (judged && !good)) m_run = 0;
      else if (good) begin
        m_run++;
        if (m_run == LOCK) m_mode = 1;
      end
      m_hist = 1;
    end else if (m_mode == 1) begin
      if (ph < 0) m_ei = 1;
      if (judged && !good) m_es = 1;
      if (ph < 0 || (judged && !good)) m_mode = 2;
      else if (good && m_prev == 5) begin
        m_cnt  = (m_cnt + 1) % (1 << CW);
        m_wrap = 1;
      end
      m_hist = 1;
    end else begin
      if (clr) begin
        m_ei = 0; m_es = 0; m_run = 0; m_mode = 0; m_hist = 0;
      end else m_hist = 1;
    end
    m_prev = ph;
  endtask

  task automatic step(input logic [2:0] code, input bit clr, input bit rst);
    jc_in   = code;
    err_clr = clr;
    reset   = rst;
    @(posedge clk);
    model(code, clr, rst);
    #1;
    if (wrap_pulse) wraps++;
    check("phase_idx",    32'(phase_idx),    32'(m_idx));
    check("phase_onehot", 32'(phase_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
    check("phase_valid",  32'(phase_valid),  32'(m_valid));
    check("locked",       32'(locked),       32'(m_mode == 1));
    check("err_illegal",  32'(err_illegal),  32'(m_ei));
    check("err_seq",      32'(err_seq),      32'(m_es));
    check("cycle_count",  32'(cycle_count),  32'(m_cnt));
    check("wrap_pulse",   32'(wrap_pulse),   32'(m_wrap));
  endtask

  int up_ph;

  task automatic free(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      step(code_of[up_ph], clr, 1'b0);
      up_ph = (up_ph + 1) % 6;
    end
  endtask

  initial begin
    int lat, c0, r;
    logic [2:0] c;
    bit rclr, rrst;
    wraps = 0;
    up_ph = 0;

    // Reset, then free-running lock latency
    step(3'b000, 1'b0, 1'b1);
    step(3'b111, 1'b1, 1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_onehot", 32'(phase_onehot), 32'd0);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      free(1, 1'b0);
      if (locked && lat == 0) lat = i;
    end
    check("lock_latency", 32'(lat), 32'd7);

    // 256 full cycles while locked
    wraps = 0;
    c0 = int'(cycle_count);
    free(6 * 256, 1'b0);
    check("wrap_pulses", 32'(wraps), 32'd256);
    check("count_wrapped", 32'(cycle_count), 32'(c0));

    // Illegal code in TRACK, then clear and relock
    step(3'b010, 1'b0, 1'b0);
    up_ph = (up_ph + 1) % 6;
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_unlock", 32'(locked), 32'd0);
    free(3, 1'b0);
    check("fault_persist", 32'(err_illegal), 32'd1);
    free(1, 1'b1);
    check("clr_flags", 32'({err_illegal, err_seq}), 32'd0);
    free(6, 1'b0);
    check("relock_early", 32'(locked), 32'd0);
    free(1, 1'b0);
    check("relock", 32'(locked), 32'd1);

    // Hold 111 for two clocks in TRACK
    while (up_ph != 2) free(1, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    up_ph = 3;
    check("hold_seq", 32'(err_seq), 32'd1);
    check("hold_ill", 32'(err_illegal), 32'd0);

    // Reset together with err_clr while faulted
    step(code_of[up_ph], 1'b1, 1'b1);
    check("rstclr_count", 32'(cycle_count), 32'd0);
    check("rstclr_flags", 32'({err_illegal, err_seq, locked}), 32'd0);

    // Skip 011->110 at run count 4 while acquiring
    up_ph = 3;
    free(5, 1'b0);
    step(code_of[3], 1'b0, 1'b0);
    up_ph = 4;
    check("skip_noflag", 32'({err_illegal, err_seq}), 32'd0);
    free(5, 1'b0);
    check("skip_nolock", 32'(locked), 32'd0);
    free(1, 1'b0);
    check("skip_relock", 32'(locked), 32'd1);

    // Random perturbations of the upstream counter
    for (int i = 0; i < 3000; i++) begin
      r    = int'($urandom_range(0, 99));
      rclr = ($urandom_range(0, 7) == 0);
      rrst = ($urandom_range(0, 299) == 0);
      if (r < 3) begin
        c = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b101;
        up_ph = (up_ph + 1) % 6;
      end else if (r < 6) begin
        c = code_of[(up_ph + 5) % 6];
      end else if (r < 9) begin
        up_ph = (up_ph + 1) % 6;
        c = code_of[up_ph];
        up_ph = (up_ph + 1) % 6;
      end else begin
        c = code_of[up_ph];
        up_ph = (up_ph + 1) % 6;
      end
      step(c, rclr, rrst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
